key_matrix_scan: RTL and testbench



---
 rtl/key_matrix_scan_pkg.sv | 19 +
 rtl/key_matrix_scan_if.sv | 12 +
 rtl/key_matrix_scan_sync_2ff.sv | 22 ++
 rtl/key_matrix_scan.sv | 176 +++++++++++++++++
 tb/tb_key_matrix_scan.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_matrix_scan_pkg.sv
// Shared types and width helpers for the key matrix scanner.
package key_scan_pkg;

    // Scanner sequencing states
    typedef enum logic [1:0] {
        SETTLE   = 2'd0,
        SAMPLE   = 2'd1,
        DEBOUNCE = 2'd2,
        REPORT   = 2'd3
    } scan_state_t;

    // $clog2 that never returns 0, so single-entry ranges still get a 1-bit field
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_matrix_scan_if.sv
// Key event channel: code, press/release flag, valid/ready handshake.
interface key_matrix_scan_if #(
    parameter int KW = 4
);
    logic [KW-1:0] okey;
    logic          opress;
    logic          ovalid;
    logic          oready;

    modport master (output okey, output opress, output ovalid, input oready);
    modport slave  (input okey, input opress, input ovalid, output oready);
endinterface

// File: rtl/key_matrix_scan_sync_2ff.sv
// Two-flop synchronizer; resets to all ones so idle pulled-up lines read as released.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] meta;

    // Double-register the asynchronous inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            dout <= '1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end
endmodule

// File: rtl/key_matrix_scan.sv
// Key matrix scanner: walks the columns, debounces any changed column with one
// shared timer, and reports each changed key as a press/release event.
//
//   state    | meaning
//   SETTLE   | column driven, waiting for rows and synchronizer to settle
//   SAMPLE   | one-cycle compare of sampled rows against the stable image
//   DEBOUNCE | change seen, holding column until rows are steady for DB_CYC
//   REPORT   | emitting one event per changed row, lowest row first
module key_matrix_scan
    import key_scan_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int CLK_FREQ   = 20,
    parameter int DELAY_TIME = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROWS-1:0]   row_in,
    output logic [COLS-1:0]   col_out,
    output logic              busy,
    key_matrix_scan_if.master evt
);
    localparam int DB_CYC = CLK_FREQ * DELAY_TIME;
    localparam int KW     = clog2_min1(ROWS * COLS);
    localparam int CW     = clog2_min1(COLS);
    localparam int RW     = clog2_min1(ROWS);
    localparam int DBW    = clog2_min1(DB_CYC + 1);
    localparam int SW     = clog2_min1(SETTLE_CYC + 1);

    scan_state_t     state;
    logic [CW-1:0]   col;
    logic [SW-1:0]   set_cnt;
    logic [DBW-1:0]  db_cnt;
    logic [ROWS-1:0] cand;
    logic [ROWS-1:0] diff;
    logic [RW-1:0]   rpt_row;
    logic [ROWS-1:0] stable [COLS];
    logic [KW-1:0]   okey;
    logic            opress;
    logic            ovalid;

    logic [ROWS-1:0] row_sync;
    logic [ROWS-1:0] samp;
    logic [ROWS-1:0] first_diff;
    logic [RW-1:0]   first_row;
    logic [ROWS-1:0] diff_rest;
    logic [RW-1:0]   rest_row;
    logic [CW-1:0]   col_nxt;

    sync_2ff #(.WIDTH(ROWS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (row_in),
        .dout  (row_sync)
    );

    assign samp = ~row_sync;

    assign evt.okey   = okey;
    assign evt.opress = opress;
    assign evt.ovalid = ovalid;

    function automatic logic [COLS-1:0] col_drive(input logic [CW-1:0] c);
        logic [COLS-1:0] d;
        d    = '1;
        d[c] = 1'b0;
        return d;
    endfunction

    function automatic logic [RW-1:0] lowest_row(input logic [ROWS-1:0] v);
        logic [RW-1:0] r;
        r = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (v[i]) r = RW'(i);
        end
        return r;
    endfunction

    function automatic logic [KW-1:0] key_code(input logic [CW-1:0] c, input logic [RW-1:0] r);
        return KW'(c) * KW'(ROWS) + KW'(r);
    endfunction

    // Priority encoding of the first pending event and the one after the current
    always_comb begin
        first_diff = cand ^ stable[col];
        first_row  = lowest_row(first_diff);
        diff_rest  = diff & ~(ROWS'(1) << rpt_row);
        rest_row   = lowest_row(diff_rest);
        col_nxt    = (col == CW'(COLS - 1)) ? '0 : col + 1'b1;
    end

    // Scan / debounce / report sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SETTLE;
            col     <= '0;
            set_cnt <= '0;
            db_cnt  <= '0;
            cand    <= '0;
            diff    <= '0;
            rpt_row <= '0;
            stable  <= '{default: '0};
            okey    <= '0;
            opress  <= 1'b0;
            ovalid  <= 1'b0;
            busy    <= 1'b0;
            col_out <= '1;
        end else begin
            case (state)
                SETTLE: begin
                    // Settling time is counted only once the column is actually driven,
                    // which matters for the first column after reset.
                    col_out <= col_drive(col);
                    if (col_out[col]) begin
                        set_cnt <= '0;
                    end else if (set_cnt == SW'(SETTLE_CYC - 1)) begin
                        set_cnt <= '0;
                        state   <= SAMPLE;
                    end else begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (samp == stable[col]) begin
                        col     <= col_nxt;
                        col_out <= col_drive(col_nxt);
                        state   <= SETTLE;
                    end else begin
                        cand   <= samp;
                        db_cnt <= '0;
                        busy   <= 1'b1;
                        state  <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (samp != cand) begin
                        db_cnt  <= '0;
                        busy    <= 1'b0;
                        col     <= col_nxt;
                        col_out <= col_drive(col_nxt);
                        state   <= SETTLE;
                    end else if (db_cnt == DBW'(DB_CYC - 1)) begin
                        diff        <= first_diff;
                        stable[col] <= cand;
                        rpt_row     <= first_row;
                        okey        <= key_code(col, first_row);
                        opress      <= cand[first_row];
                        ovalid      <= 1'b1;
                        state       <= REPORT;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                REPORT: begin
                    if (ovalid && evt.oready) begin
                        diff <= diff_rest;
                        if (diff_rest != '0) begin
                            rpt_row <= rest_row;
                            okey    <= key_code(col, rest_row);
                            opress  <= cand[rest_row];
                        end else begin
                            ovalid  <= 1'b0;
                            busy    <= 1'b0;
                            col     <= col_nxt;
                            col_out <= col_drive(col_nxt);
                            state   <= SETTLE;
                        end
                    end
                end
                default: state <= SETTLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: ideal key matrix model, scoreboard of expected events.
module tb_key_matrix_scan;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int KW   = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [ROWS-1:0] row_in;
    logic [COLS-1:0] col_out;
    logic            busy;
    logic [ROWS-1:0] keys [COLS];
    int              ready_mode = 2;

    typedef struct packed {
        logic [KW-1:0] key;
        logic          press;
    } ev_t;

    ev_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  cyc         = 0;
    int  hs_cycle    = -1;
    int  prev_hs     = -1;

    key_matrix_scan_if #(.KW(KW)) evt ();

    key_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .CLK_FREQ(2), .DELAY_TIME(5), .SETTLE_CYC(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .row_in  (row_in),
        .col_out (col_out),
        .busy    (busy),
        .evt     (evt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Ideal matrix: a row reads low when a closed key sits on a driven column
    always_comb begin
        row_in = '1;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (keys[c][r] === 1'b1 && col_out[c] === 1'b0) row_in[r] = 1'b0;
    end

    // Consumer ready: 0 = stalled, 1 = random, 2 = always ready
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       evt.oready = 1'b0;
            1:       evt.oready = 1'($urandom_range(0, 1));
            default: evt.oready = 1'b1;
        endcase
    end

    // Monitor: every accepted event must match the head of the scoreboard
    always @(negedge clk) begin
        ev_t e;
        if (rst_n && evt.ovalid && evt.oready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got key=%0d press=%0d, expected none",
                         evt.okey, evt.opress);
            end else begin
                e = exp_q.pop_front();
                if (evt.okey !== e.key || evt.opress !== e.press) begin
                    miscompares++;
                    $display("FAIL event: got key=%0d press=%0d, expected key=%0d press=%0d",
                             evt.okey, evt.opress, e.key, e.press);
                end
            end
            prev_hs  = hs_cycle;
            hs_cycle = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out", name);
    endtask

    // Flip a set of keys on one column and queue the resulting events, lowest row first
    task automatic toggle(input int c, input logic [ROWS-1:0] mask);
        ev_t e;
        for (int r = 0; r < ROWS; r++) begin
            if (mask[r]) begin
                e.key   = KW'(c * ROWS + r);
                e.press = ~keys[c][r];
                exp_q.push_back(e);
            end
        end
        keys[c] = keys[c] ^ mask;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            timeout_fail(name);
            exp_q.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        int col;
        logic [3:0] ec;
        logic saw_busy;
        logic [ROWS-1:0] m;

        for (int c = 0; c < COLS; c++) keys[c] = '0;

        // 1. reset values, then the idle scan pattern
        repeat (3) @(negedge clk);
        chk("rst_col_out", col_out, 4'hF);
        chk("rst_ovalid", evt.ovalid, 0);
        chk("rst_okey", evt.okey, 0);
        chk("rst_opress", evt.opress, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            col = (i / 5) % COLS;
            ec = 4'hF;
            ec[col] = 1'b0;
            chk("scan_col_out", col_out, ec);
        end
        chk("idle_ovalid", evt.ovalid, 0);

        // 2. clean press and release of row2/col1
        ready_mode = 2;
        @(negedge clk);
        toggle(1, 4'b0100);
        wait_drain("press_k6", 300);
        toggle(1, 4'b0100);
        wait_drain("release_k6", 300);
        idle(30);

        // 3. bounce on row1/col0 shorter than the debounce window
        n = 0;
        while (col_out == 4'b1110 && n < 100) begin @(negedge clk); n++; end
        while (col_out != 4'b1110 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout_fail("bounce_find_col0");
        keys[0][1] = 1'b1;
        saw_busy = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        keys[0][1] = 1'b0;
        n = 0;
        while (busy && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) timeout_fail("bounce_abort");
        chk("bounce_entered_debounce", saw_busy, 1);
        chk("bounce_resume_col1", col_out, 4'b1101);
        idle(40);

        // 4. stalled consumer holds the event and the column
        toggle(3, 4'b1000);
        ready_mode = 0;
        n = 0;
        while (!evt.ovalid && n < 200) begin @(negedge clk); n++; end
        chk("stall_ovalid", evt.ovalid, 1);
        chk("stall_okey", evt.okey, 15);
        chk("stall_opress", evt.opress, 1);
        chk("stall_col_out", col_out, 4'b0111);
        repeat (20) begin
            @(negedge clk);
            chk("stall_hold", {evt.ovalid, evt.okey, evt.opress, col_out}, {1'b1, 4'd15, 1'b1, 4'b0111});
        end
        ready_mode = 2;
        wait_drain("stall_release", 50);
        toggle(3, 4'b1000);
        wait_drain("release_k15", 300);

        // 5. two keys on one column report in adjacent handshake cycles
        toggle(2, 4'b1001);
        wait_drain("press_k8_k11", 300);
        chk("b2b_press_gap", hs_cycle - prev_hs, 1);
        toggle(2, 4'b1001);
        wait_drain("release_k8_k11", 300);
        chk("b2b_release_gap", hs_cycle - prev_hs, 1);

        // Randomized changes with a randomly stalling consumer
        ready_mode = 1;
        for (int it = 0; it < 16; it++) begin
            col = $urandom_range(0, COLS - 1);
            m = ROWS'($urandom_range(1, (1 << ROWS) - 1));
            toggle(col, m);
            wait_drain("random_step", 600);
            idle(5);
        end
        ready_mode = 2;
        for (int c = 0; c < COLS; c++) begin
            if (keys[c] != '0) begin
                toggle(c, keys[c]);
                wait_drain("release_all", 300);
            end
        end
        idle(30);

        // 6. reset in the middle of a debounce drops everything
        keys[0][0] = 1'b1;
        n = 0;
        while (!busy && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout_fail("rst_find_debounce");
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        keys[0][0] = 1'b0;
        #1;
        chk("midrst_col_out", col_out, 4'hF);
        chk("midrst_ovalid", evt.ovalid, 0);
        chk("midrst_okey", evt.okey, 0);
        chk("midrst_opress", evt.opress, 0);
        chk("midrst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_restart_col0", col_out, 4'b1110);
        idle(80);
        chk("midrst_no_event_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
